argmax_unit: RTL and testbench

//  Final stage of the neural_network datapath. After the output layer writes
//  NUM_CLASSES signed scores into the score memory, this block reads them

---
 rtl/argmax_unit.sv | 128 ++++++++++++
 tb/tb_argmax_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : argmax_unit                                                   |
// | Brief    : Sequential scan of the score memory; reports index of the     |
// |            largest signed score. Define ARGMAX_SCORE_OUT_EN for max_score.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module argmax_unit #(
   parameter int NUM_CLASSES  = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   output logic [ADDR_WIDTH-1:0]        score_read_addr,
   input  logic signed [DATA_WIDTH-1:0] score_data_in,
   output logic                         busy,
   output logic                         done,
   output logic [3:0]                   argmax_output
`ifdef ARGMAX_SCORE_OUT_EN
   ,
   output logic signed [DATA_WIDTH-1:0] max_score
`endif
);

   localparam int                    c_wait_w    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] c_last_idx  = ADDR_WIDTH'(NUM_CLASSES - 1);
   localparam logic [c_wait_w-1:0]   c_wait_init = c_wait_w'(READ_LATENCY - 1);
   localparam logic [3:0]            c_no_result = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_CMP,
      S_DONE
   } state_t;

   state_t                       r_state;
   logic [c_wait_w-1:0]          r_wait;
   logic [ADDR_WIDTH-1:0]        r_idx;
   logic [ADDR_WIDTH-1:0]        r_best_idx;
   logic signed [DATA_WIDTH-1:0] r_best;

   logic                         w_take;
   logic signed [DATA_WIDTH-1:0] w_next_best;
   logic [ADDR_WIDTH-1:0]        w_next_best_idx;

   // Strict compare keeps the earliest index on ties; index 0 always seeds.
   assign w_take          = (r_idx == '0) || (score_data_in > r_best);
   assign w_next_best     = w_take ? score_data_in : r_best;
   assign w_next_best_idx = w_take ? r_idx : r_best_idx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= S_IDLE;
         r_wait          <= '0;
         r_idx           <= '0;
         r_best_idx      <= '0;
         r_best          <= '0;
         score_read_addr <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         argmax_output   <= c_no_result;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state         <= S_ADDR;
                  r_idx           <= '0;
                  score_read_addr <= '0;
                  busy            <= 1'b1;
                  argmax_output   <= c_no_result;
               end
            end
            S_ADDR: begin
               r_state <= S_WAIT;
               r_wait  <= c_wait_init;
            end
            S_WAIT: begin
               if (r_wait == '0) begin
                  r_state <= S_CMP;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            S_CMP: begin
               r_best     <= w_next_best;
               r_best_idx <= w_next_best_idx;
               if (r_idx == c_last_idx) begin
                  r_state       <= S_DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  argmax_output <= 4'(w_next_best_idx);
               end else begin
                  r_idx           <= r_idx + 1'b1;
                  score_read_addr <= r_idx + 1'b1;
                  r_state         <= S_ADDR;
               end
            end
            S_DONE: begin
               // Level handshake: a held start never retriggers a scan.
               if (!start) begin
                  r_state <= S_IDLE;
                  done    <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ARGMAX_SCORE_OUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         max_score <= '0;
      end else if (r_state == S_IDLE && start) begin
         max_score <= '0;
      end else if (r_state == S_CMP && r_idx == c_last_idx) begin
         max_score <= w_next_best;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_argmax_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_argmax_unit                                                |
// | Brief    : Scoreboard bench for argmax_unit at READ_LATENCY 1 and 3.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_argmax_unit;
   localparam int N  = 10;
   localparam int DW = 32;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   logic [AW-1:0] addr1, addr3;
   logic signed [DW-1:0] data1, data3;
   logic busy1, busy3, done1, done3;
   logic [3:0] am1, am3;
`ifdef ARGMAX_SCORE_OUT_EN
   logic signed [DW-1:0] ms1, ms3;
`endif

   always #5 clk = ~clk;

   argmax_unit #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1), .score_read_addr(addr1),
      .score_data_in(data1), .busy(busy1), .done(done1), .argmax_output(am1)
`ifdef ARGMAX_SCORE_OUT_EN
      , .max_score(ms1)
`endif
   );

   argmax_unit #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
      .clk(clk), .resetn(resetn), .start(start3), .score_read_addr(addr3),
      .score_data_in(data3), .busy(busy3), .done(done3), .argmax_output(am3)
`ifdef ARGMAX_SCORE_OUT_EN
      , .max_score(ms3)
`endif
   );

   // Score memory shared by both instances (only one scans at a time).
   logic signed [DW-1:0] mem [N];
   logic [AW-1:0] p1;
   logic [AW-1:0] p3 [3];
   always @(posedge clk) begin
      p1    <= addr1;
      p3[0] <= addr3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign data1 = (int'(p1) < N)    ? mem[int'(p1)]    : 32'sh5A5A_A5A5;
   assign data3 = (int'(p3[2]) < N) ? mem[int'(p3[2])] : 32'sh5A5A_A5A5;

   typedef struct {
      int                   inst;
      int                   idx;
      logic signed [DW-1:0] best;
      int                   lat;
      int                   sc;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: tracks scan activity and pops the scoreboard on each done rise.
   logic          pb = 1'b0, pd1 = 1'b0, pd3 = 1'b0;
   logic [N-1:0]  seen;
   int            maxa;
   logic          midbad;
   logic [AW-1:0] ma;
   logic [3:0]    mm;
   exp_t          me;

   always @(negedge clk) begin
      ma = busy3 ? addr3 : addr1;
      mm = busy3 ? am3 : am1;
      if ((busy1 | busy3) && !pb) begin
         seen = '0; maxa = 0; midbad = 1'b0;
      end
      if (busy1 | busy3) begin
         if (int'(ma) > maxa) maxa = int'(ma);
         if (int'(ma) < N) seen[ma] = 1'b1;
         if (mm != 4'd10) midbad = 1'b1;
`ifdef ARGMAX_SCORE_OUT_EN
         if ((busy3 ? ms3 : ms1) != 0) midbad = 1'b1;
`endif
      end
      if ((done1 && !pd1) || (done3 && !pd3)) begin
         if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got a done rise, expected no pending scan");
         end else begin
            me = q.pop_front();
            chk("argmax", longint'(me.inst == 3 ? am3 : am1), longint'(me.idx));
            chk("latency", longint'(cyc - me.sc), longint'(me.lat));
            chk("addr_cover", longint'(seen), (longint'(1) << N) - 1);
            chk("addr_max", longint'(maxa), longint'(N - 1));
            chk("mid_scan_outputs", longint'(midbad), 0);
            chk("busy_at_done", longint'(me.inst == 3 ? busy3 : busy1), 0);
`ifdef ARGMAX_SCORE_OUT_EN
            chk("max_score", longint'(me.inst == 3 ? ms3 : ms1), longint'(me.best));
`endif
         end
      end
      pb  = busy1 | busy3;
      pd1 = done1;
      pd3 = done3;
   end

   // Reference: first index holding the largest signed score.
   task automatic run_scan(input int inst, input int hold);
      exp_t e;
      int   bi;
      logic got;
      logic held_ok;
      bi = 0;
      for (int i = 1; i < N; i++) if (mem[i] > mem[bi]) bi = i;
      e.inst = inst; e.idx = bi; e.best = mem[bi];
      e.lat  = N * (2 + ((inst == 3) ? 3 : 1));
      @(negedge clk);
      e.sc = cyc + 1;
      q.push_back(e);
      if (inst == 3) start3 = 1'b1; else start1 = 1'b1;
      got = 1'b0;
      for (int k = 0; k < e.lat + 20; k++) begin
         @(negedge clk);
         if ((inst == 3) ? done3 : done1) begin got = 1'b1; break; end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", e.lat + 20);
         q.delete();
      end
      held_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (!((inst == 3) ? done3 : done1) || ((inst == 3) ? busy3 : busy1)) held_ok = 1'b0;
      end
      if (hold > 0) chk("held_start_single_scan", longint'(held_ok), 1);
      start1 = 1'b0; start3 = 1'b0;
      @(negedge clk);
      chk("done_drop", longint'((inst == 3) ? done3 : done1), 0);
      chk("argmax_hold", longint'((inst == 3) ? am3 : am1), longint'(bi));
   endtask

   int t1[N] = '{5, -3, 7, 2, 0, 1, 9, 4, 8, 6};

   initial begin
      #2 resetn = 1'b0;
      #1;
      chk("rst_busy", longint'(busy1), 0);
      chk("rst_done", longint'(done1), 0);
      chk("rst_argmax", longint'(am1), 10);
      chk("rst_addr", longint'(addr1), 0);
`ifdef ARGMAX_SCORE_OUT_EN
      chk("rst_max_score", longint'(ms1), 0);
`endif
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < N; i++) mem[i] = t1[i];
      run_scan(1, 0);
      for (int i = 0; i < N; i++) mem[i] = -100;
      mem[3] = -1;
      run_scan(1, 0);
      for (int i = 0; i < N; i++) mem[i] = 0;
      mem[2] = 50; mem[7] = 50;
      run_scan(1, 0);
      for (int i = 0; i < N; i++) mem[i] = 32'sh8000_0000;
      run_scan(1, 0);

      // Reset twelve clocks into a scan: no result may survive.
      for (int i = 0; i < N; i++) mem[i] = t1[i];
      @(negedge clk);
      start1 = 1'b1;
      repeat (12) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("abort_busy", longint'(busy1), 0);
      chk("abort_done", longint'(done1), 0);
      chk("abort_argmax", longint'(am1), 10);
      start1 = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      run_scan(1, 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r[0]) mem[i] = int'($urandom_range(0, 6)) - 3;
            else      mem[i] = $urandom;
         end
         if (r == 6) mem[N-1] = 32'sh7FFF_FFFF;
         run_scan(1, int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < N; i++) mem[i] = $urandom;
      run_scan(1, 100);
      for (int i = 0; i < N; i++) mem[i] = t1[i];
      run_scan(3, 0);
      for (int i = 0; i < N; i++) mem[i] = int'($urandom_range(0, 4)) - 2;
      run_scan(3, 2);

      repeat (3) @(negedge clk);
      chk("queue_empty", longint'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion, expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
